// File: rtl/key_search_pkg.sv
// key_search_pkg: shared types and constants for the brute-force key search controller
package ks_pkg;

    localparam int DEFAULT_KEY_W       = 24;
    localparam int DEFAULT_SEARCH_BITS = 22;

    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RD_WAIT,
        CHECK,
        NEXT_KEY,
        FOUND,
        FAIL
    } ks_state_t;

endpackage

// File: rtl/key_search_if.sv
// key_search_if: key/start/finished handshake and decrypted-RAM read port towards arcfour
interface key_search_if #(
    parameter int KEY_W  = 24,
    parameter int ADDR_W = 5
);

    logic [KEY_W-1:0]  key;
    logic              crack_start;
    logic              crack_finished;
    logic [ADDR_W-1:0] dmem_addr;
    logic [7:0]        dmem_q;

    modport master (
        output key,
        output crack_start,
        output dmem_addr,
        input  crack_finished,
        input  dmem_q
    );

    modport slave (
        input  key,
        input  crack_start,
        input  dmem_addr,
        output crack_finished,
        output dmem_q
    );

endinterface

// File: rtl/key_search_valid_char.sv
// valid_char: classifies a decrypted byte as acceptable plaintext (lowercase; space too with KEY_SEARCH_SPACE_EN)
module valid_char
    import ks_pkg::*;
(
    input  logic [7:0] b,
    output logic       ok
);

    logic lower;

    assign lower = (b >= CHAR_A) && (b <= CHAR_Z);

`ifdef KEY_SEARCH_SPACE_EN
    assign ok = lower || (b == CHAR_SPACE);
`else
    assign ok = lower;
`endif

endmodule

// File: rtl/trap_edge.sv
// trap_edge: single-cycle rising-edge detector for a level input
module trap_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev_q;

    // remember last cycle's level so a level already high never counts as an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else        prev_q <= sig;
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/key_search.sv
// key_search: brute-force key controller that drives arcfour and validates the decrypted message
module key_search
    import ks_pkg::*;
#(
    parameter int KEY_W       = DEFAULT_KEY_W,
    parameter int SEARCH_BITS = DEFAULT_SEARCH_BITS,
    parameter int MSG_LEN     = 32,
    parameter int ADDR_W      = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_sig,
    input  logic [SEARCH_BITS-1:0] key_first,
    input  logic [SEARCH_BITS-1:0] key_last,
    key_search_if.master           bus,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

    ks_state_t              state_q, state_d;
    logic [SEARCH_BITS-1:0] key_q, key_d;
    logic [SEARCH_BITS-1:0] last_q, last_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   found_q, found_d;
    logic                   exh_q, exh_d;
    logic                   fin_rise;
    logic                   byte_ok;

    trap_edge u_fin_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (bus.crack_finished),
        .rise  (fin_rise)
    );

    valid_char u_valid_char (
        .b  (bus.dmem_q),
        .ok (byte_ok)
    );

    // next-state and next-output logic of the search sequencer
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        last_d  = last_q;
        addr_d  = addr_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        found_d = found_q;
        exh_d   = exh_q;
        case (state_q)
            IDLE: begin
                if (start_sig) begin
                    key_d   = key_first;
                    last_d  = key_last;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    if (key_first > key_last) begin
                        state_d = FAIL;
                    end else begin
                        busy_d  = 1'b1;
                        start_d = 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (fin_rise) begin
                    addr_d  = '0;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT:   state_d = CHECK;
            CHECK: begin
                if (!byte_ok) begin
                    state_d = NEXT_KEY;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = FOUND;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_WAIT;
                end
            end
            NEXT_KEY: begin
                if (key_q == last_q) begin
                    state_d = FAIL;
                end else begin
                    key_d   = key_q + 1'b1;
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end
            end
            FOUND: begin
                found_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            FAIL: begin
                exh_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any search without emitting a pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            last_q  <= '0;
            addr_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            found_q <= found_d;
            exh_q   <= exh_d;
        end
    end

    assign bus.key         = KEY_W'(key_q);
    assign bus.crack_start = start_q;
    assign bus.dmem_addr   = addr_q;
    assign busy            = busy_q;
    assign found           = found_q;
    assign exhausted       = exh_q;

endmodule

// File: tb/tb_key_search.sv
// tb_key_search: directed vectors against a behavioural arcfour/RAM model
module tb_key_search;

    localparam int SB = 22;

`ifdef KEY_SEARCH_SPACE_EN
    localparam logic SPACE_OK = 1'b1;
`else
    localparam logic SPACE_OK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_sig = 1'b0;
    logic [SB-1:0] key_first = '0;
    logic [SB-1:0] key_last = '0;
    logic          busy, found, exhausted;

    key_search_if #(.KEY_W(24), .ADDR_W(5)) bus ();

    key_search dut (
        .clk       (clk),
        .reset     (reset),
        .start_sig (start_sig),
        .key_first (key_first),
        .key_last  (key_last),
        .bus       (bus),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]   good_key = 32'hFFFF_FFFF;
    logic [7:0]    tail_b = 8'h7A;
    logic [7:0]    mid_b = 8'h61;
    logic [SB-1:0] cur_key = '0;
    logic          fin = 1'b1;
    logic          ready = 1'b1;
    int            cnt = 0;
    int            launches = 0;

    assign bus.crack_finished = fin;

    function automatic logic [7:0] msg_byte(input logic [SB-1:0] k, input logic [4:0] a);
        if (32'(k) != good_key) return (a == 5'd3) ? 8'h40 : 8'h61;
        if (a == 5'd31) return tail_b;
        if (a == 5'd10) return mid_b;
        return 8'h61;
    endfunction

    // arcfour model: finished stays high one cycle after start, drops, then rises after a delay
    always @(posedge clk) begin
        if (bus.crack_start) begin
            cur_key  <= bus.key[SB-1:0];
            cnt      <= 8;
            ready    <= 1'b0;
            launches <= launches + 1;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 7) fin <= 1'b0;
            if (cnt == 1) begin
                fin   <= 1'b1;
                ready <= 1'b1;
            end
        end
        bus.dmem_q <= ready ? msg_byte(cur_key, bus.dmem_addr) : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [SB-1:0] first, input logic [SB-1:0] last,
                       output int n, output int cyc);
        int base;
        base = launches;
        @(negedge clk);
        key_first = first;
        key_last  = last;
        start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        cyc = 1;
        while (!(found || exhausted) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check("done", 32'(found | exhausted), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        n = launches - base;
    endtask

    initial begin
        int n, cyc, base;
        #12;
        check("rst_key", bus.key, 32'h0);
        check("rst_cs", 32'(bus.crack_start), 32'd0);
        check("rst_addr", 32'(bus.dmem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_exh", 32'(exhausted), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        good_key = 32'h249; tail_b = 8'h7A; mid_b = 8'h61;
        run(22'h240, 22'h250, n, cyc);
        check("main_launches", 32'(n), 32'd10);
        check("main_found", 32'(found), 32'd1);
        check("main_exh", 32'(exhausted), 32'd0);
        check("main_key", bus.key, 32'h249);

        good_key = 32'hFFFF_FFFF;
        run(22'h10, 22'h10, n, cyc);
        check("none_launches", 32'(n), 32'd1);
        check("none_exh", 32'(exhausted), 32'd1);
        check("none_found", 32'(found), 32'd0);
        check("none_key", bus.key, 32'h10);

        run(22'h5, 22'h3, n, cyc);
        check("inv_launches", 32'(n), 32'd0);
        check("inv_exh", 32'(exhausted), 32'd1);
        check("inv_fast", 32'(cyc <= 3), 32'd1);
        check("inv_key", bus.key, 32'h5);

        run(22'h3FFFFE, 22'h3FFFFF, n, cyc);
        check("top_launches", 32'(n), 32'd2);
        check("top_exh", 32'(exhausted), 32'd1);
        check("top_key", bus.key, 32'h3FFFFF);

        good_key = 32'h77; tail_b = 8'h7A; mid_b = 8'h61;
        run(22'h77, 22'h77, n, cyc);
        check("z_found", 32'(found), 32'd1);
        tail_b = 8'h7B;
        run(22'h77, 22'h77, n, cyc);
        check("brace_found", 32'(found), 32'd0);
        check("brace_exh", 32'(exhausted), 32'd1);
        tail_b = 8'h7A; mid_b = 8'h20;
        run(22'h77, 22'h77, n, cyc);
        check("space_found", 32'(found), 32'(SPACE_OK));
        check("space_exh", 32'(exhausted), 32'(!SPACE_OK));

        good_key = 32'h249; mid_b = 8'h61;
        @(negedge clk);
        key_first = 22'h240;
        key_last  = 22'h250;
        start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        cyc = 0;
        while (bus.dmem_addr != 5'd2 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach", 32'(bus.dmem_addr), 32'd2);
        key_first = 22'h100;
        key_last  = 22'h200;
        start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        check("busy_norestart_key", bus.key, 32'h240);
        check("busy_norestart_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (bus.dmem_addr != 5'd3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_key", bus.key, 32'h0);
        check("arst_cs", 32'(bus.crack_start), 32'd0);
        check("arst_addr", 32'(bus.dmem_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_found", 32'(found), 32'd0);
        check("arst_exh", 32'(exhausted), 32'd0);
        base = launches;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_launches", 32'(launches - base), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_search.md
Name: key_search

Overview:
- Brute-force key controller sitting directly upstream of arcfour.
- Drives arcfour's key and start_sig, waits for arcfour_finished, then reads back the decrypted-message RAM.
- Accepts a key only if every decrypted byte is a lowercase letter. Otherwise advances to the next key until the programmed range is exhausted.
- Result is reported on status outputs for LEDR/HEX display at top level.

Parameters:
- KEY_W, 24, width of key bus to arcfour.
- SEARCH_BITS, 22, low key bits searched; bits KEY_W-1..SEARCH_BITS are always 0.
- MSG_LEN, 32, decrypted-message length in bytes.
- ADDR_W, 5, decrypted-RAM address width (2**ADDR_W >= MSG_LEN).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- start_sig  in  1  single-cycle start pulse (from trap_edge).
- key_first  in  SEARCH_BITS  first key tried; sampled at start.
- key_last  in  SEARCH_BITS  last key tried (inclusive); sampled at start.
- key  out  KEY_W  key presented to arcfour.
- crack_start  out  1  one-cycle pulse to arcfour start_sig.
- crack_finished  in  1  arcfour_finished level.
- dmem_addr  out  ADDR_W  decrypted-RAM read address.
- dmem_q  in  8  decrypted-RAM read data; valid 1 cycle after dmem_addr.
- busy  out  1  search in progress.
- found  out  1  sticky: key holds a valid key.
- exhausted  out  1  sticky: range searched, no valid key.

Behaviour:
- Reset (reset==0, asynchronous):
  - state IDLE.
  - key=0, crack_start=0, dmem_addr=0, busy=0, found=0, exhausted=0.
  - Internal key_last register=0.
- State IDLE:
  - On start_sig: latch key_first/key_last; clear found/exhausted.
  - If key_first > key_last, go to FAIL. Otherwise key <= {0, key_first}, busy=1, go to LAUNCH.
  - start_sig while busy is ignored (no restart).
- State LAUNCH:
  - crack_start=1 for exactly one cycle, then go to WAIT_DONE.
- State WAIT_DONE:
  - Wait for a rising edge of crack_finished (0->1); a level already high at LAUNCH does not count.
  - On the edge: dmem_addr=0, go to RD_WAIT.
- State RD_WAIT:
  - One bubble cycle for RAM latency, then go to CHECK.
- State CHECK (samples dmem_q for address dmem_addr):
  - Invalid byte: go to NEXT_KEY.
  - Valid byte and dmem_addr==MSG_LEN-1: go to FOUND.
  - Valid byte otherwise: dmem_addr+1, go to RD_WAIT.
  - Per-byte cost is 2 cycles.
- Valid byte: 8'h61..8'h7A inclusive (plus space, see Optional Feature).
- State NEXT_KEY:
  - If key[SEARCH_BITS-1:0]==key_last, go to FAIL.
  - Otherwise key+1, go to LAUNCH.
  - Key never wraps; key_last = all-ones terminates without overflow.
- State FOUND:
  - found=1, busy=0, key held. Go to IDLE.
- State FAIL:
  - exhausted=1, busy=0, key holds last key tried (key_first if range inverted). Go to IDLE.
- found and exhausted are mutually exclusive; both clear only on the next accepted start or on reset.
- Reset mid-search aborts immediately with no pulse emitted. Resetting arcfour is the top level's job (shared reset).
- key and dmem_addr are registered outputs, with no combinational path from inputs.

Optional Feature:
- Macro KEY_SEARCH_SPACE_EN.
- Defined: byte 8'h20 (space) is also valid.
- Undefined: only 8'h61..8'h7A are valid; 8'h20 rejects the key.

Decomposition:
- Package ks_pkg holds:
  - state enum ks_state_t {IDLE, LAUNCH, WAIT_DONE, RD_WAIT, CHECK, NEXT_KEY, FOUND, FAIL}.
  - Constants CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SPACE=8'h20.
  - Defaults KEY_W, SEARCH_BITS.
- The existing trap_edge is reused for crack_finished rising-edge detection.
- One natural sub-module: valid_char (combinational byte classifier, carries the macro), so the checker can be unit-tested alone.

Test Plan:
- Behavioural arcfour/RAM model.
  - Stimulus: key_first=0x000240, key_last=0x000250; model yields valid text only for key 0x000249.
  - Required: 10 crack_start pulses, then found=1, key=0x000249, busy=0.
- Range with no valid key.
  - Stimulus: key_first=key_last=0x000010, model always invalid.
  - Required: exactly 1 crack_start, exhausted=1, found=0, key=0x000010.
- Inverted range.
  - Stimulus: key_first=0x000005, key_last=0x000003.
  - Required: no crack_start, exhausted=1 within 3 cycles.
- Range ending at all-ones.
  - Stimulus: key_first=0x3FFFFE, key_last=0x3FFFFF, all invalid.
  - Required: 2 launches, exhausted=1, key=0x3FFFFF, no wrap to 0.
- Boundary characters.
  - Stimulus: message all 8'h61 except byte 31=8'h7A, then a separate run with byte 31=8'h7B.
  - Required: found for the first run; the second run rejects the key.
  - Space check: byte 8'h20 accepted only when KEY_SEARCH_SPACE_EN is defined.
- Reset mid-search.
  - Stimulus: reset low during CHECK, start_sig pulsed while busy.
  - Required: reset gives all outputs 0 immediately; start_sig while busy causes no restart.
